// File: rtl/ktc32_io_pkg.sv
// Shared ktc32 data-bus definitions: memwrite encoding, I/O register offsets,
// CTRL bit indices and the byte-lane helpers also used by the RAM.
package ktc32_io_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_BYTE = 2'b01,
    MW_HALF = 2'b10,
    MW_WORD = 2'b11
  } memwrite_e;

  localparam logic [2:0] REG_OUT     = 3'd0;
  localparam logic [2:0] REG_IN      = 3'd1;
  localparam logic [2:0] REG_EDGE    = 3'd2;
  localparam logic [2:0] REG_EDGE_EN = 3'd3;
  localparam logic [2:0] REG_TIMER   = 3'd4;
  localparam logic [2:0] REG_CMP     = 3'd5;
  localparam logic [2:0] REG_STATUS  = 3'd6;
  localparam logic [2:0] REG_CTRL    = 3'd7;

  localparam int CTRL_TIMER_EN = 0;
  localparam int CTRL_MATCH_EN = 1;

  // Halfword writes ignore addr[0]; word writes ignore both low bits.
  function automatic logic [3:0] byte_en(input logic [1:0] mw, input logic [1:0] a);
    case (mw)
      MW_BYTE: byte_en = 4'b0001 << a;
      MW_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      MW_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    for (int i = 0; i < 4; i++) lane_mask[i*8 +: 8] = {8{be[i]}};
  endfunction

  // Right-aligned write data replicated so every enabled lane sees it.
  function automatic logic [31:0] lane_data(input logic [1:0] mw, input logic [31:0] d);
    case (mw)
      MW_BYTE: lane_data = {4{d[7:0]}};
      MW_HALF: lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One input channel: 2-flop synchroniser followed by a counting debouncer.
// rise is combinational and high in the cycle before level goes 0->1.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d_async,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // The counter only survives while the synced pin disagrees with level.
  always_comb begin
    sync_d  = {sync_q[0], d_async};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) level_d = ~level_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/mmio_gpio_timer.sv
// Memory-mapped GPIO + timer peripheral on the ktc32 data bus: LED outputs,
// debounced inputs with sticky rising-edge capture, timer compare and irq.
module mmio_gpio_timer
  import ktc32_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_8000,
  parameter int          N_OUT           = 4,
  parameter int          N_IN            = 4,
  parameter int          DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [1:0]       memwrite,
  input  logic [31:0]      addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             hit,
  input  logic [N_IN-1:0]  btn_in,
  output logic [N_OUT-1:0] led,
  output logic             irq
);

  logic [N_OUT-1:0] out_q, out_d;
  logic [N_IN-1:0]  edge_q, edge_d, edge_en_q, edge_en_d;
  logic [N_IN-1:0]  in_level, in_rise;
  logic [31:0]      timer_q, timer_d, cmp_q, cmp_d;
  logic             status_q, status_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             irq_q, irq_d;
  logic [2:0]       offset;
  logic             wr_en, match;
  logic [31:0]      wmask, wdata;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .n_reset (n_reset),
      .d_async (btn_in[i]),
      .level   (in_level[i]),
      .rise    (in_rise[i])
    );
  end

  assign hit    = (addr[31:5] == BASE_ADDR[31:5]);
  assign offset = addr[4:2];
  assign wr_en  = hit && (memwrite != MW_NONE);
  assign wmask  = lane_mask(byte_en(memwrite, addr[1:0]));
  assign wdata  = lane_data(memwrite, wd);
  assign match  = ctrl_q[CTRL_TIMER_EN] && (timer_q == cmp_q);

  // W1C registers: hardware sets are applied after the clear so set wins.
  always_comb begin
    out_d     = out_q;
    edge_d    = edge_q;
    edge_en_d = edge_en_q;
    timer_d   = ctrl_q[CTRL_TIMER_EN] ? timer_q + 32'd1 : timer_q;
    cmp_d     = cmp_q;
    status_d  = status_q;
    ctrl_d    = ctrl_q;
    if (wr_en) begin
      case (offset)
        REG_OUT:     out_d     = (out_q & ~wmask[N_OUT-1:0]) | (wdata[N_OUT-1:0] & wmask[N_OUT-1:0]);
        REG_EDGE:    edge_d    = edge_q & ~(wdata[N_IN-1:0] & wmask[N_IN-1:0]);
        REG_EDGE_EN: edge_en_d = (edge_en_q & ~wmask[N_IN-1:0]) | (wdata[N_IN-1:0] & wmask[N_IN-1:0]);
        REG_TIMER:   timer_d   = (timer_q & ~wmask) | (wdata & wmask);
        REG_CMP:     cmp_d     = (cmp_q & ~wmask) | (wdata & wmask);
        REG_STATUS:  if (wmask[0] && wdata[0]) status_d = 1'b0;
        REG_CTRL:    ctrl_d    = (ctrl_q & ~wmask[1:0]) | (wdata[1:0] & wmask[1:0]);
        default:     ;
      endcase
    end
    edge_d = edge_d | in_rise;
    if (match) status_d = 1'b1;
    irq_d = (|(edge_q & edge_en_q)) | (status_q & ctrl_q[CTRL_MATCH_EN]);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_q     <= '0;
      edge_q    <= '0;
      edge_en_q <= '0;
      timer_q   <= '0;
      cmp_q     <= 32'hFFFF_FFFF;
      status_q  <= 1'b0;
      ctrl_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      edge_q    <= edge_d;
      edge_en_q <= edge_en_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      status_q  <= status_d;
      ctrl_q    <= ctrl_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      case (offset)
        REG_OUT:     rd = 32'(out_q);
        REG_IN:      rd = 32'(in_level);
        REG_EDGE:    rd = 32'(edge_q);
        REG_EDGE_EN: rd = 32'(edge_en_q);
        REG_TIMER:   rd = timer_q;
        REG_CMP:     rd = cmp_q;
        REG_STATUS:  rd = {31'd0, status_q};
        REG_CTRL:    rd = {30'd0, ctrl_q};
        default:     rd = '0;
      endcase
    end
  end

  assign led = out_q;
  assign irq = irq_q;

endmodule

// File: doc/mmio_gpio_timer.md
Name: mmio_gpio_timer

Overview:
- Parametrised memory-mapped I/O peripheral on the ktc32 data bus (memwrite/addr/wd/rd). It replaces the fixed 4-LED output previously folded into RAM.
- Provides N_OUT output pins, N_IN debounced input pins with sticky rising-edge capture, and a 32-bit timer with compare match.
- Raises a level interrupt from any pending event.
- The board top decodes `hit` to steer `rd` between RAM and this block.

Parameters:
- BASE_ADDR, 32'h0000_8000, byte address of register 0; aligned to 32 bytes.
- N_OUT, 4, output pin count (1..32).
- N_IN, 4, input pin count (1..32).
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept an input change (>=1; benches use 4).

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- memwrite  in  2  write size: 00 none, 01 byte, 10 halfword, 11 word.
- addr  in  32  byte address from core.
- wd  in  32  write data, right-aligned (low bits).
- rd  out  32  read data, combinational from registers for the current addr; 0 when not hit.
- hit  out  1  combinational; high when addr[31:5] == BASE_ADDR[31:5].
- btn_in  in  N_IN  raw asynchronous pins.
- led  out  N_OUT  driven directly from the OUT register.
- irq  out  1  registered; |(EDGE & EDGE_EN) | (STATUS.match & CTRL.match_en).

Behaviour:
- **Register map** (offset = addr[4:2]):
  - 0 OUT RW
  - 1 IN RO (debounced levels)
  - 2 EDGE W1C (sticky rising edges)
  - 3 EDGE_EN RW
  - 4 TIMER RW
  - 5 CMP RW
  - 6 STATUS W1C (bit0 = match)
  - 7 CTRL RW (bit0 = timer_en, bit1 = match_en)
- Unused register bits read 0. Writes to RO bits or offset 1 are ignored.
- **Reset** (async assert, sync-release use is the top's concern):
  - OUT, EDGE, EDGE_EN, TIMER, STATUS, CTRL, irq = 0; CMP = 32'hFFFF_FFFF.
  - Debounced levels and sync flops = 0, so led = 0 and irq = 0 during and after reset.
- **Writes:**
  - Take effect at the clock edge where hit=1 and memwrite!=00.
  - Byte write: only lane addr[1:0] changes, loaded from wd[7:0].
  - Halfword write: lane pair addr[1] changes, loaded from wd[15:0]; addr[0] is ignored.
  - Word write: addr[1:0] ignored.
  - W1C registers clear the bits written as 1 within the written lanes.
- **Reads:** zero latency, so a single-cycle core sees a value in the same cycle. A read in the same cycle as a write returns the pre-write value.
- **Inputs:**
  - Each pin passes through a 2-flop synchroniser, then its own debouncer.
  - A per-channel counter increments while synced != stable level and clears when they match.
  - On reaching DEBOUNCE_CYCLES-1 the stable level toggles and the counter clears.
  - Pin-to-IN latency is 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES are never visible.
- **EDGE:** bit set on a stable 0->1 transition. Set and W1C in the same cycle: set wins.
- **TIMER:**
  - Increments by 1 each cycle while timer_en=1 and wraps FFFF_FFFF -> 0 with no flag.
  - A software write to TIMER overrides the increment that cycle.
  - STATUS.match sets on any edge where the TIMER register currently equals CMP and timer_en=1.
  - Set and W1C of match in the same cycle: set wins.
  - Writing CMP does not clear a pending match.
- **irq:** one-cycle registered delay from the EDGE/STATUS/enable state; stays high until the cause is cleared.
- **Reset mid-debounce:** counters and levels return to 0 immediately; an input held high re-qualifies after a full 2 + DEBOUNCE_CYCLES cycles.

Decomposition:
- Package ktc32_io_pkg:
  - memwrite encoding enum (MW_NONE, MW_BYTE, MW_HALF, MW_WORD).
  - Register offset localparams.
  - CTRL bit indices.
  - Function computing the byte-enable mask from memwrite and addr[1:0], shared with ram.
- Sub-module io_debounce (one per input, generate loop): parameter DEBOUNCE_CYCLES; ports clk, n_reset, d_async, level, rise.

Test Plan:
- Reset, then word write 0x0000_000A to BASE+0 -> led = 4'b1010 next cycle; read BASE+0 returns 0xA same cycle; with addr = BASE+0x20, hit=0 and rd=0.
- Byte write 0xFF to BASE+1 (lane 1) after OUT=0x5 -> OUT reads 0x0000_FF05 masked to N_OUT, so led stays 4'b0101.
- DEBOUNCE_CYCLES=4:
  - btn_in[2] high for 3 cycles then low -> IN stays 0, EDGE stays 0.
  - Held high -> IN[2]=1 exactly 6 cycles after the pin rises; EDGE[2]=1.
  - With EDGE_EN[2]=1, irq rises one cycle later.
  - Word write 0x4 to BASE+8 -> EDGE=0 and irq falls next cycle.
- Set TIMER=0xFFFF_FFFE, CMP=1, CTRL=0x3 -> TIMER reads FFFF_FFFF, 0, 1; STATUS.match sets on the edge where TIMER=1; irq high next cycle.
- W1C to STATUS in the same cycle as a new match (TIMER=CMP held via CTRL timer_en=1 and rewrite TIMER=CMP) -> match remains 1.
- Assert n_reset mid-debounce and with OUT=0xF, irq=1 -> led and irq drop to 0 asynchronously before the next clk edge; all registers read reset values after release.
